// File: rtl/sdrx_sequencer.sv
// SD multi-block read sequencer: gates the SD clock on FIFO room, arms and clears
// the frame receiver per block, times out a missing start bit and requests CMD12.
module sdrx_sequencer #(
  parameter int LGLEN     = 15,
  parameter int LGNBLK    = 16,
  parameter int LGTIMEOUT = 24
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [LGNBLK-1:0]    i_nblocks,
  input  logic [LGLEN-2:0]     i_blklen,
  input  logic [LGTIMEOUT-1:0] i_timeout,
  input  logic [LGLEN-1:0]     i_room,
  input  logic                 i_stb,
  input  logic                 i_dat0,
  input  logic                 i_frame_done,
  input  logic                 i_frame_err,
  input  logic                 i_stop_ack,
  output logic                 o_clk_en,
  output logic                 o_frame_en,
  output logic                 o_frame_clear,
  output logic [LGLEN-1:0]     o_frame_length,
  output logic                 o_stop_req,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [1:0]           o_err,
  output logic [LGNBLK-1:0]    o_blocks
);

  // state       | meaning
  // IDLE        | waiting for i_start, SD clock off
  // WAIT_ROOM   | clock held off until FIFO can take a whole block
  // WAIT_START  | receiver armed, clock running, start-bit timeout active
  // RECEIVE     | frame in progress, waiting for done/err
  // STOP        | CMD12 requested, waiting for the command path to accept
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_ROOM, S_WAIT_START, S_RECEIVE, S_STOP
  } state_t;

  localparam logic [LGNBLK-1:0]    ONE_BLK = 1;
  localparam logic [LGTIMEOUT-1:0] ONE_T   = 1;

  state_t               state_q, state_d;
  logic [LGNBLK-1:0]    nblk_q, nblk_d;
  logic [LGNBLK-1:0]    blocks_q, blocks_d;
  logic [LGLEN-2:0]     blklen_q, blklen_d;
  logic [LGTIMEOUT-1:0] tmo_q, tmo_d;
  logic [LGTIMEOUT-1:0] tcnt_q, tcnt_d;
  logic [1:0]           err_q, err_d;
  logic                 done_q, done_d;
  logic                 room_ok, start_bit, last_blk, clear;

  assign room_ok   = i_room >= {1'b0, blklen_q};
  assign start_bit = i_stb && !i_dat0;
  assign last_blk  = (blocks_q + ONE_BLK) == nblk_q;

  always_comb begin
    state_d  = state_q;
    nblk_d   = nblk_q;
    blocks_d = blocks_q;
    blklen_d = blklen_q;
    tmo_d    = tmo_q;
    tcnt_d   = tcnt_q;
    err_d    = err_q;
    done_d   = 1'b0;
    clear    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start && (i_nblocks != '0)) begin
          nblk_d   = i_nblocks;
          blklen_d = i_blklen;
          tmo_d    = i_timeout;
          blocks_d = '0;
          err_d    = 2'd0;
          state_d  = S_WAIT_ROOM;
        end
      end
      S_WAIT_ROOM: begin
        if (i_abort) begin
          err_d   = 2'd3;
          state_d = S_STOP;
        end else if (room_ok) begin
          clear   = 1'b1;
          tcnt_d  = tmo_q;
          state_d = S_WAIT_START;
        end
      end
      S_WAIT_START: begin
        // start bit is checked before the timeout so it wins a tie on the same strobe
        if (i_abort) begin
          err_d   = 2'd3;
          state_d = S_STOP;
        end else if (start_bit) begin
          state_d = S_RECEIVE;
        end else if (i_stb && (tmo_q != '0)) begin
          tcnt_d = tcnt_q - ONE_T;
          if (tcnt_q <= ONE_T) begin
            err_d   = 2'd1;
            state_d = S_STOP;
          end
        end
      end
      S_RECEIVE: begin
        if (i_abort) begin
          err_d   = 2'd3;
          state_d = S_STOP;
        end else if (i_frame_err) begin
          err_d   = 2'd2;
          state_d = S_STOP;
        end else if (i_frame_done) begin
          blocks_d = blocks_q + ONE_BLK;
          state_d  = last_blk ? S_STOP : S_WAIT_ROOM;
        end
      end
      S_STOP: begin
        if (i_stop_ack) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= S_IDLE;
      nblk_q   <= '0;
      blocks_q <= '0;
      blklen_q <= '0;
      tmo_q    <= '0;
      tcnt_q   <= '0;
      err_q    <= 2'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      nblk_q   <= nblk_d;
      blocks_q <= blocks_d;
      blklen_q <= blklen_d;
      tmo_q    <= tmo_d;
      tcnt_q   <= tcnt_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  assign o_clk_en       = (state_q == S_WAIT_START) || (state_q == S_RECEIVE) || (state_q == S_STOP);
  assign o_frame_en     = (state_q == S_WAIT_START) || (state_q == S_RECEIVE);
  assign o_frame_clear  = clear;
  assign o_frame_length = {blklen_q, 1'b0};
  assign o_stop_req     = state_q == S_STOP;
  assign o_busy         = state_q != S_IDLE;
  assign o_done         = done_q;
  assign o_err          = err_q;
  assign o_blocks       = blocks_q;

endmodule

// File: tb/tb_sdrx_sequencer.sv
// Randomized bench for sdrx_sequencer: per-transaction block plans are scored by a
// transaction-level model; a monitor matches each o_done against the queued outcome.
module tb_sdrx_sequencer;

  localparam int GOOD = 0, CRC = 1, CRC_DONE = 2, ABORT_DONE = 3;
  localparam int ABORT_WS = 4, TIMEOUT = 5, ABORT_WR = 6;

  logic        i_clk, i_reset_n, i_start, i_abort;
  logic [15:0] i_nblocks;
  logic [13:0] i_blklen;
  logic [23:0] i_timeout;
  logic [14:0] i_room;
  logic        i_stb, i_dat0, i_frame_done, i_frame_err, i_stop_ack;
  logic        o_clk_en, o_frame_en, o_frame_clear, o_stop_req, o_busy, o_done;
  logic [14:0] o_frame_length;
  logic [1:0]  o_err;
  logic [15:0] o_blocks;

  sdrx_sequencer #(.LGLEN(15), .LGNBLK(16), .LGTIMEOUT(24)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_start(i_start), .i_abort(i_abort),
    .i_nblocks(i_nblocks), .i_blklen(i_blklen), .i_timeout(i_timeout), .i_room(i_room),
    .i_stb(i_stb), .i_dat0(i_dat0), .i_frame_done(i_frame_done), .i_frame_err(i_frame_err),
    .i_stop_ack(i_stop_ack), .o_clk_en(o_clk_en), .o_frame_en(o_frame_en),
    .o_frame_clear(o_frame_clear), .o_frame_length(o_frame_length), .o_stop_req(o_stop_req),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_blocks(o_blocks)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    int err;
    int blocks;
    int clears;
    int fl;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   clr_cnt = 0;
  int   plan_oc[$];
  int   plan_k[$];
  int   plan_d[$];
  int   low_room_fix = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction outcome straight from the block plan, independent of any cycle timing.
  function automatic exp_t model(input int blen);
    exp_t e;
    e.err = 0; e.blocks = 0; e.clears = 0; e.fl = blen * 2;
    for (int b = 0; b < plan_oc.size(); b++) begin
      if (plan_oc[b] == ABORT_WR) begin
        e.err = 3;
        break;
      end
      e.clears++;
      case (plan_oc[b])
        GOOD:                 e.blocks++;
        CRC, CRC_DONE:        e.err = 2;
        ABORT_DONE, ABORT_WS: e.err = 3;
        default:              e.err = 1;
      endcase
      if (plan_oc[b] != GOOD) break;
    end
    return e;
  endfunction

  always @(negedge i_clk) begin
    if (!i_reset_n) begin
      clr_cnt = 0;
    end else begin
      if (o_frame_clear) begin
        clr_cnt++;
        if (exp_q.size() > 0) check("frame_length", o_frame_length, exp_q[0].fl);
      end
      if (o_done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got o_done=1 expected no completion at %0t", $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("done_err", o_err, e.err);
          check("done_blocks", o_blocks, e.blocks);
          check("done_clears", clr_cnt, e.clears);
          check("done_not_busy", o_busy, 0);
        end
        clr_cnt = 0;
      end
    end
  end

  task automatic cyc();
    @(posedge i_clk);
    #1;
    i_start = 0; i_abort = 0; i_stb = 0; i_dat0 = 1;
    i_frame_done = 0; i_frame_err = 0; i_stop_ack = 0;
  endtask

  task automatic sample();
    @(negedge i_clk);
  endtask

  function automatic int room_low(input int blen);
    if (low_room_fix >= 0) return low_room_fix;
    return $urandom_range(0, blen - 1);
  endfunction

  function automatic int room_high(input int blen);
    if ($urandom_range(0, 1) == 0) return blen;
    return blen + $urandom_range(1, 100);
  endfunction

  // idle strobe-free cycles, sometimes carrying a start request that must be ignored
  task automatic stb_gap();
    repeat ($urandom_range(0, 2)) begin
      cyc();
      if ($urandom_range(0, 3) == 0) begin
        i_start = 1;
        i_nblocks = 16'd5;
        i_blklen = 14'($urandom_range(1, 16383));
      end
    end
  endtask

  task automatic add_blk(input int oc, input int k, input int d);
    plan_oc.push_back(oc);
    plan_k.push_back(k);
    plan_d.push_back(d);
  endtask

  task automatic clear_plan();
    plan_oc.delete();
    plan_k.delete();
    plan_d.delete();
  endtask

  task automatic run_txn(input int nblk, input int blen, input int tmo, input int rst_blk);
    exp_t e;
    int   oc;
    int   nhigh;
    bit   rst_hit;
    rst_hit = 0;
    e = model(blen);
    cyc();
    i_start = 1; i_nblocks = 16'(nblk); i_blklen = 14'(blen); i_timeout = 24'(tmo);
    i_room = 15'((plan_k[0] > 0) ? room_low(blen) : room_high(blen));
    if (rst_blk < 0) exp_q.push_back(e);
    for (int b = 0; b < plan_oc.size(); b++) begin
      oc = plan_oc[b];
      if (oc == ABORT_WR) begin
        cyc(); i_abort = 1; i_room = 15'(room_high(blen));
        sample(); check("clear_vs_abort", o_frame_clear, 0);
        break;
      end
      for (int i = 0; i < plan_k[b]; i++) begin
        cyc(); sample();
        check("wait_room_outputs", {o_clk_en, o_frame_en, o_frame_clear, o_busy}, 4'b0001);
      end
      cyc(); i_room = 15'(room_high(blen));
      sample(); check("frame_clear", o_frame_clear, 1);
      cyc(); sample(); check("armed_after_clear", {o_clk_en, o_frame_en, o_stop_req}, 3'b110);
      nhigh = (oc == TIMEOUT) ? tmo : plan_d[b];
      for (int j = 1; j <= nhigh; j++) begin
        stb_gap();
        cyc(); i_stb = 1; i_dat0 = 1;
        if (oc == TIMEOUT && j == tmo - 1) begin
          cyc(); sample(); check("timeout_not_yet", o_stop_req, 0);
        end
        if (oc == TIMEOUT && j == tmo) begin
          cyc(); sample(); check("timeout_expired", {o_stop_req, o_err}, 3'b101);
        end
      end
      if (oc == TIMEOUT) break;
      stb_gap();
      if (oc == ABORT_WS) begin
        cyc(); i_abort = 1;
        break;
      end
      cyc(); i_stb = 1; i_dat0 = 0;
      cyc(); sample(); check("receiving", {o_clk_en, o_frame_en, o_stop_req}, 3'b110);
      if (b == rst_blk) begin
        cyc(); #1 i_reset_n = 0; #1;
        check("rst_ctrl", {o_clk_en, o_frame_en, o_frame_clear, o_stop_req, o_busy, o_done, o_err}, 0);
        check("rst_len", o_frame_length, 0);
        check("rst_blocks", o_blocks, 0);
        cyc(); cyc(); i_reset_n = 1;
        rst_hit = 1;
        break;
      end
      repeat ($urandom_range(0, 4)) cyc();
      cyc();
      case (oc)
        GOOD:     i_frame_done = 1;
        CRC:      i_frame_err = 1;
        CRC_DONE: begin i_frame_err = 1; i_frame_done = 1; end
        default:  begin i_abort = 1; i_frame_done = 1; end
      endcase
      if (oc != GOOD) break;
      if (b + 1 < plan_oc.size())
        i_room = 15'((plan_k[b+1] > 0) ? room_low(blen) : room_high(blen));
    end
    if (rst_hit) return;
    cyc(); sample();
    check("stop_state", {o_stop_req, o_frame_en, o_clk_en, o_busy}, 4'b1011);
    repeat ($urandom_range(0, 3)) begin
      cyc();
      if ($urandom_range(0, 1) == 0) i_abort = 1;
    end
    cyc(); i_stop_ack = 1;
    cyc(); sample(); check("after_ack", {o_stop_req, o_busy, o_done}, 3'b001);
    cyc(); i_abort = 1;
    cyc(); sample();
    check("err_held", o_err, e.err);
    check("blocks_held", o_blocks, e.blocks);
  endtask

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got no end of test expected finish before 500000");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int nblk, blen, tmo, r, oc;
    i_reset_n = 0; i_start = 0; i_abort = 0; i_nblocks = 0; i_blklen = 0; i_timeout = 0;
    i_room = 0; i_stb = 0; i_dat0 = 1; i_frame_done = 0; i_frame_err = 0; i_stop_ack = 0;
    repeat (3) @(posedge i_clk);
    sample();
    check("reset_ctrl", {o_clk_en, o_frame_en, o_frame_clear, o_stop_req, o_busy, o_done, o_err}, 0);
    check("reset_blocks_len", {o_blocks, o_frame_length}, 0);
    cyc(); i_reset_n = 1;

    cyc(); i_start = 1; i_nblocks = 0; i_blklen = 14'd100;
    cyc(); sample(); check("zero_nblocks_ignored", {o_busy, o_frame_length}, 0);

    clear_plan(); repeat (3) add_blk(GOOD, 0, 9);
    run_txn(3, 512, 0, -1);
    clear_plan(); add_blk(TIMEOUT, 0, 0);
    run_txn(2, 512, 100, -1);
    clear_plan(); add_blk(GOOD, 0, 2); add_blk(CRC, 0, 3);
    run_txn(4, 512, 0, -1);
    low_room_fix = 300;
    clear_plan(); add_blk(GOOD, 0, 1); add_blk(GOOD, 3, 4);
    run_txn(2, 512, 50, -1);
    low_room_fix = -1;
    clear_plan(); add_blk(GOOD, 0, 0); add_blk(ABORT_DONE, 1, 2);
    run_txn(2, 512, 0, -1);
    clear_plan(); repeat (3) add_blk(GOOD, 0, 1);
    run_txn(3, 512, 0, 1);
    clear_plan(); add_blk(GOOD, 0, 2);
    run_txn(1, 512, 0, -1);

    repeat (40) begin
      nblk = $urandom_range(1, 4);
      blen = $urandom_range(1, 2000);
      tmo  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 12);
      clear_plan();
      for (int b = 0; b < nblk; b++) begin
        r = $urandom_range(0, 99);
        if      (r < 55) oc = GOOD;
        else if (r < 63) oc = CRC;
        else if (r < 70) oc = CRC_DONE;
        else if (r < 77) oc = ABORT_DONE;
        else if (r < 84) oc = ABORT_WS;
        else if (r < 92) oc = TIMEOUT;
        else             oc = ABORT_WR;
        if (oc == TIMEOUT && tmo == 0) oc = GOOD;
        add_blk(oc, $urandom_range(0, 2), (tmo == 0) ? $urandom_range(0, 12) : $urandom_range(0, tmo - 1));
        if (oc != GOOD) break;
      end
      run_txn(nblk, blen, tmo, -1);
    end

    repeat (3) cyc();
    check("all_done_seen", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
